// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the two-requester APB arbiter slice.
//   DEF_ADDR_WIDTH / DEF_DATA_WIDTH / DEF_TIMEOUT : parameter defaults
//   NUM_REQ          : number of requesters (fixed at two)
//   apb_ctl_state_e  : APB transfer FSM states
//   is_word_aligned  : true when the byte address is 32-bit aligned
// ---------------------------------------------------------------------------
package apb_pkg;

   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_TIMEOUT    = 16;
   localparam int NUM_REQ        = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_ctl_state_e;

   function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter_if
// Bundles the requester-side handshake and the APB completer-side bus of the
// arbiter.
//   Requester side : req_valid/req_ready/req_write/req_addr/req_wdata/req_strb,
//                    rsp_valid/rsp_rdata/rsp_err
//   APB side       : psel/penable/pwrite/paddr/pwdata/pstrb,
//                    prdata/pready/pslverr
// Modports:
//   slave  : the arbiter (accepts requests, drives the APB bus)
//   master : the environment (issues requests, acts as APB completer)
// ---------------------------------------------------------------------------
interface apb_req_arbiter_if
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   // requester side
   logic [NUM_REQ-1:0]                 req_valid;
   logic [NUM_REQ-1:0]                 req_ready;
   logic [NUM_REQ-1:0]                 req_write;
   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0][STRB_WIDTH-1:0] req_strb;
   logic [NUM_REQ-1:0]                 rsp_valid;
   logic [DATA_WIDTH-1:0]              rsp_rdata;
   logic                               rsp_err;

   // APB side
   logic                               psel;
   logic                               penable;
   logic                               pwrite;
   logic [ADDR_WIDTH-1:0]              paddr;
   logic [DATA_WIDTH-1:0]              pwdata;
   logic [STRB_WIDTH-1:0]              pstrb;
   logic [DATA_WIDTH-1:0]              prdata;
   logic                               pready;
   logic                               pslverr;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_strb,
      input  prdata, pready, pslverr,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output psel, penable, pwrite, paddr, pwdata, pstrb
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_strb,
      output prdata, pready, pslverr,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  psel, penable, pwrite, paddr, pwdata, pstrb
   );

endinterface

// File: rtl/apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// apb_rr_arbiter
// Two-way round-robin grant. A lone requester always wins; when both request,
// the one that was not granted last wins. The last-grant record only moves
// when the owner of the grant actually has its request accepted.
//   pclk, presetn : clock, asynchronous active-low reset
//   i_req         : per-requester request
//   i_accept      : the current grant was taken this cycle
//   o_gnt         : one-hot (or zero) grant, combinational
//   o_gnt_idx     : index of the granted requester
// ---------------------------------------------------------------------------
module apb_rr_arbiter
   import apb_pkg::*;
(
   input  logic               pclk,
   input  logic               presetn,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_accept,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic               o_gnt_idx
);

   // Starts at 1 so requester 0 takes the first tie.
   logic r_last_grant;

   always_comb begin
      o_gnt = '0;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = r_last_grant ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

   assign o_gnt_idx = o_gnt[1];

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_last_grant <= 1'b1;
      end else if (i_accept) begin
         r_last_grant <= o_gnt_idx;
      end
   end

endmodule

// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter
// Arbitrates two requesters onto one APB completer, one transfer in flight.
//   pclk    : clock, all state on the rising edge
//   presetn : asynchronous active-low reset
//   bus     : apb_req_arbiter_if.slave
//             requester handshake (req_*), completion (rsp_*), APB master bus
// A misaligned request is answered with an error straight from IDLE without
// any APB cycle. A transfer left in ACCESS for TIMEOUT cycles without pready
// is closed with an error. All APB and response outputs are registered.
// ---------------------------------------------------------------------------
module apb_req_arbiter
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic             pclk,
   input  logic             presetn,
   apb_req_arbiter_if.slave bus
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   // Counter holds 0..TIMEOUT-1: number of ACCESS cycles already spent waiting.
   localparam int CNT_WIDTH  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

   apb_ctl_state_e          r_state;
   logic                    r_owner;
   logic [CNT_WIDTH-1:0]    r_cnt;
   logic                    r_psel;
   logic                    r_penable;
   logic                    r_pwrite;
   logic [ADDR_WIDTH-1:0]   r_paddr;
   logic [DATA_WIDTH-1:0]   r_pwdata;
   logic [STRB_WIDTH-1:0]   r_pstrb;
   logic [NUM_REQ-1:0]      r_rsp_valid;
   logic                    r_rsp_err;
   logic [DATA_WIDTH-1:0]   r_rsp_rdata;

   logic [NUM_REQ-1:0]      w_gnt;
   logic                    w_gnt_idx;
   logic                    w_idle;
   logic                    w_accept;
   logic                    w_sel_write;
   logic [ADDR_WIDTH-1:0]   w_sel_addr;
   logic [DATA_WIDTH-1:0]   w_sel_wdata;
   logic [STRB_WIDTH-1:0]   w_sel_strb;
   logic                    w_sel_aligned;

   assign w_idle   = (r_state == IDLE);
   // The grant only carries bits for valid requesters, so any grant in IDLE
   // is a completed handshake.
   assign w_accept = w_idle & (|w_gnt);

   apb_rr_arbiter u_rr_arbiter (
      .pclk      (pclk),
      .presetn   (presetn),
      .i_req     (bus.req_valid),
      .i_accept  (w_accept),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx)
   );

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign bus.req_ready[gi] = w_idle & w_gnt[gi];
      end
   endgenerate

   assign w_sel_write   = bus.req_write[w_gnt_idx];
   assign w_sel_addr    = bus.req_addr[w_gnt_idx];
   assign w_sel_wdata   = bus.req_wdata[w_gnt_idx];
   assign w_sel_strb    = bus.req_strb[w_gnt_idx];
   assign w_sel_aligned = is_word_aligned(w_sel_addr[1:0]);

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state     <= IDLE;
         r_owner     <= 1'b0;
         r_cnt       <= '0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_pstrb     <= '0;
         r_rsp_valid <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         // Completion is a single-cycle pulse; data/err are zero outside it.
         r_rsp_valid <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;

         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_owner <= w_gnt_idx;
                  if (w_sel_aligned) begin
                     r_psel    <= 1'b1;
                     r_penable <= 1'b0;
                     r_pwrite  <= w_sel_write;
                     r_paddr   <= w_sel_addr;
                     // Reads never present write data or strobes on the bus.
                     r_pwdata  <= w_sel_write ? w_sel_wdata : '0;
                     r_pstrb   <= w_sel_write ? w_sel_strb  : '0;
                     r_state   <= SETUP;
                  end else begin
                     r_rsp_valid[w_gnt_idx] <= 1'b1;
                     r_rsp_err              <= 1'b1;
                  end
               end
            end

            SETUP: begin
               r_penable <= 1'b1;
               r_cnt     <= '0;
               r_state   <= ACCESS;
            end

            ACCESS: begin
               if (bus.pready) begin
                  r_psel               <= 1'b0;
                  r_penable            <= 1'b0;
                  r_state              <= IDLE;
                  r_rsp_valid[r_owner] <= 1'b1;
                  r_rsp_err            <= bus.pslverr;
                  r_rsp_rdata          <= (!r_pwrite && !bus.pslverr) ? bus.prdata : '0;
               end else if (r_cnt == CNT_LAST) begin
                  // TIMEOUT ACCESS cycles elapsed with no pready.
                  r_psel               <= 1'b0;
                  r_penable            <= 1'b0;
                  r_state              <= IDLE;
                  r_cnt                <= '0;
                  r_rsp_valid[r_owner] <= 1'b1;
                  r_rsp_err            <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            default: begin
               r_psel    <= 1'b0;
               r_penable <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.psel      = r_psel;
   assign bus.penable   = r_penable;
   assign bus.pwrite    = r_pwrite;
   assign bus.paddr     = r_paddr;
   assign bus.pwdata    = r_pwdata;
   assign bus.pstrb     = r_pstrb;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_req_arbiter
// Requester drivers push the expected outcome of every accepted request into
// a scoreboard queue; a negedge monitor compares grants, APB phases and
// completions against the queue head. The completer answers according to
// the plan stored with each queued transaction.
// ---------------------------------------------------------------------------
module tb_apb_req_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 16;

   typedef struct {
      int            owner;
      bit            wr;
      bit            mis;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] strb;
      int            w;        // ACCESS wait cycles before pready; >= TO means never
      bit            perr;
      logic [DW-1:0] prd;
      bit            exp_err;
      logic [DW-1:0] exp_rd;
      int            a;        // cycle index right after the accept edge
      int            due;      // cycle index in which rsp_valid must show
   } rec_t;

   logic pclk = 1'b0;
   logic presetn = 1'b0;
   always #5 pclk = ~pclk;

   apb_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   apb_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .pclk    (pclk),
      .presetn (presetn),
      .bus     (bus)
   );

   logic          drv_valid [2];
   logic          drv_write [2];
   logic [AW-1:0] drv_addr  [2];
   logic [DW-1:0] drv_wdata [2];
   logic [SW-1:0] drv_strb  [2];

   assign bus.req_valid = {drv_valid[1], drv_valid[0]};
   assign bus.req_write = {drv_write[1], drv_write[0]};
   assign bus.req_addr  = {drv_addr[1],  drv_addr[0]};
   assign bus.req_wdata = {drv_wdata[1], drv_wdata[0]};
   assign bus.req_strb  = {drv_strb[1],  drv_strb[0]};

   rec_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   lg_m = 1'b1;
   int   first_owner = -1;
   int   acc_n = 0;

   always @(posedge pclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
      end
   endtask

   // Present one request, wait (bounded) for the handshake, record the
   // expected outcome, then drop valid just after the accept edge.
   task automatic send(input int r, input bit wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [SW-1:0] st,
                       input int w, input bit perr, input logic [DW-1:0] prd);
      rec_t e;
      bit   got;
      bit   to;
      drv_valid[r] = 1'b1;
      drv_write[r] = wr;
      drv_addr[r]  = addr;
      drv_wdata[r] = wd;
      drv_strb[r]  = st;
      got = 1'b0;
      for (int k = 0; k < 300 && !got; k++) begin
         @(negedge pclk);
         if (presetn && bus.req_valid[r] && bus.req_ready[r]) got = 1'b1;
      end
      chk($sformatf("accept_r%0d", r), 64'(got), 64'(1));
      if (got) begin
         e.owner = r;   e.wr = wr;     e.addr = addr;
         e.wdata = wd;  e.strb = st;   e.w = w;
         e.perr = perr; e.prd = prd;
         e.mis   = (addr[1:0] != 2'b00);
         to      = !e.mis && (w >= TO);
         e.exp_err = e.mis || to || perr;
         e.exp_rd  = (!e.mis && !to && !wr && !perr) ? prd : '0;
         e.a   = cyc + 1;
         e.due = e.mis ? e.a : (to ? e.a + TO + 1 : e.a + 2 + w);
         exp_q.push_back(e);
         if (first_owner < 0) first_owner = r;
      end
      @(posedge pclk);
      #1;
      drv_valid[r] = 1'b0;
   endtask

   task automatic drv(input int r);
      int            idle;
      logic [AW-1:0] a;
      int            w;
      for (int i = 0; i < 40; i++) begin
         idle = int'($urandom_range(0, 3));
         if (idle > 0) begin
            repeat (idle) @(posedge pclk);
            #1;
         end
         a = AW'($urandom) & 32'h0000_0FFC;
         if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
         w = ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(0, 3));
         send(r, 1'($urandom), a, DW'($urandom), SW'($urandom), w,
              ($urandom_range(0, 3) == 0), DW'($urandom));
      end
   endtask

   // Completer: raises pready on the planned ACCESS cycle, noise otherwise.
   always @(negedge pclk) begin
      if (!presetn || !bus.psel || !bus.penable || exp_q.size() == 0) begin
         acc_n       = 0;
         bus.pready  = 1'b0;
         bus.pslverr = 1'($urandom);
         bus.prdata  = DW'($urandom);
      end else begin
         acc_n++;
         if (!exp_q[0].mis && exp_q[0].w < TO && acc_n == exp_q[0].w + 1) begin
            bus.pready  = 1'b1;
            bus.pslverr = exp_q[0].perr;
            bus.prdata  = exp_q[0].prd;
         end else begin
            bus.pready  = 1'b0;
            bus.pslverr = 1'($urandom);
            bus.prdata  = DW'($urandom);
         end
      end
   end

   // Monitor / scoreboard.
   always @(negedge pclk) begin : mon
      rec_t       e;
      logic [1:0] v;
      logic [1:0] eg;
      logic [1:0] eo;
      bit         busy;
      if (!presetn) begin
         lg_m = 1'b1;
      end else begin
         v    = bus.req_valid;
         busy = (exp_q.size() > 0) && !exp_q[0].mis &&
                (cyc >= exp_q[0].a) && (cyc < exp_q[0].due);

         chk("penable_without_psel", 64'(bus.penable & ~bus.psel), 64'(0));

         if (busy)            eg = 2'b00;
         else if (v == 2'b11) eg = lg_m ? 2'b01 : 2'b10;
         else                 eg = v;
         chk("req_ready", 64'(bus.req_ready), 64'(eg));
         if (eg != 2'b00) lg_m = eg[1];

         if (busy) begin
            e = exp_q[0];
            chk("apb_ctl", 64'({bus.psel, bus.penable}), 64'({1'b1, (cyc != e.a)}));
            chk("pwrite_paddr", 64'({bus.pwrite, bus.paddr}), 64'({e.wr, e.addr}));
            chk("pstrb_pwdata", 64'({bus.pstrb, bus.pwdata}),
                64'({(e.wr ? e.strb : 4'h0), (e.wr ? e.wdata : 32'h0)}));
         end else begin
            chk("apb_idle", 64'({bus.psel, bus.penable}), 64'(0));
         end

         if (bus.rsp_valid != 2'b00 || (exp_q.size() > 0 && cyc >= exp_q[0].due)) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
            end else begin
               e  = exp_q.pop_front();
               eo = (e.owner == 1) ? 2'b10 : 2'b01;
               chk("rsp_owner", 64'(bus.rsp_valid), 64'(eo));
               chk("rsp_cycle", 64'(cyc), 64'(e.due));
               chk("rsp_err",   64'(bus.rsp_err), 64'(e.exp_err));
               chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.exp_rd));
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ctl"},   64'({bus.psel, bus.penable, bus.pwrite}), 64'(0));
      chk({tag, "_paddr"}, 64'(bus.paddr), 64'(0));
      chk({tag, "_pdata"}, 64'({bus.pstrb, bus.pwdata}), 64'(0));
      chk({tag, "_rsp"},   64'({bus.rsp_valid, bus.rsp_err}), 64'(0));
      chk({tag, "_rdata"}, 64'(bus.rsp_rdata), 64'(0));
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(posedge pclk);
      chk({tag, "_drain"}, 64'(exp_q.size()), 64'(0));
      @(posedge pclk);
      #1;
   endtask

   initial begin
      for (int r = 0; r < 2; r++) begin
         drv_valid[r] = 1'b0; drv_write[r] = 1'b0; drv_addr[r] = '0;
         drv_wdata[r] = '0;   drv_strb[r]  = '0;
      end
      presetn = 1'b0;
      repeat (2) @(posedge pclk);
      #2;
      check_reset_outputs("reset_init");
      @(posedge pclk);
      #3;
      presetn = 1'b1;
      @(posedge pclk);
      #1;

      // Directed cases.
      send(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEEF);   // zero-wait read
      send(0, 1'b0, 32'h3, 32'h0, 4'h0, 0, 1'b0, 32'h12345678);   // misaligned
      send(1, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 3, 1'b1, 32'h0);   // waits + slverr
      send(0, 1'b1, 32'h10, 32'h1111, 4'h3, TO + 4, 1'b0, 32'h0); // timeout
      send(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 32'hA5A5A5A5);  // served after timeout
      drain("directed");

      // Both requesters continuously valid: grants must alternate.
      fork
         begin
            for (int i = 0; i < 4; i++) send(0, 1'b1, 32'h10, 32'h1000 + i, 4'h5, 0, 1'b0, 32'h0);
         end
         begin
            for (int i = 0; i < 4; i++) send(1, 1'b1, 32'h20, 32'h2000 + i, 4'hA, 0, 1'b0, 32'h0);
         end
      join
      drain("alternate");

      // Randomized traffic.
      fork
         drv(0);
         drv(1);
      join
      drain("random");

      // Reset while in ACCESS.
      send(0, 1'b0, 32'h30, 32'h0, 4'h0, TO + 8, 1'b0, 32'h0);
      repeat (3) @(posedge pclk);
      #3;
      presetn = 1'b0;
      exp_q.delete();
      #1;
      check_reset_outputs("reset_mid");
      repeat (2) @(posedge pclk);
      #3;
      presetn = 1'b1;
      repeat (6) @(posedge pclk);
      #1;
      first_owner = -1;
      fork
         send(0, 1'b0, 32'h40, 32'h0, 4'h0, 1, 1'b0, 32'h01020304);
         send(1, 1'b0, 32'h44, 32'h0, 4'h0, 0, 1'b0, 32'h05060708);
      join
      chk("post_reset_first_owner", 64'(first_owner), 64'(0));
      drain("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
